// File: rtl/sr_cmd_if.sv
// ---------------------------------------------------------------------------
// sr_cmd_if
// Bundles the raw request lines and the command/status outputs of the SR
// command generator.
//   set_in   : raw asynchronous set request        (requester -> generator)
//   clr_in   : raw asynchronous clear request      (requester -> generator)
//   s, r     : one-cycle set / clear pulses        (generator -> SR stage)
//   busy     : pulse cycle plus spacing gap active (generator -> requester)
//   conflict : both requests met at one arbitration point
//   overrun  : request arrived while one was already pending on that channel
// The master modport is the requesting side; the slave modport is the
// generator itself.
// ---------------------------------------------------------------------------
interface sr_cmd_if;
    logic set_in;
    logic clr_in;
    logic s;
    logic r;
    logic busy;
    logic conflict;
    logic overrun;

    modport master (
        output set_in, clr_in,
        input  s, r, busy, conflict, overrun
    );

    modport slave (
        input  set_in, clr_in,
        output s, r, busy, conflict, overrun
    );
endinterface

// File: rtl/sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen
// Upstream command stage for the SR flip-flop stage. Each raw request line is
// synchronised (2 flops), debounced, and every debounced rising edge becomes
// a pending request. A small arbiter issues pending requests as one-cycle
// s/r pulses, never both at once, spaced by at least MIN_GAP idle cycles.
//
// Ports:
//   clk    : single clock, all state on the rising edge
//   reset  : synchronous, active-high; clears every register
//   bus    : sr_cmd_if.slave (set_in, clr_in in; s, r, busy, conflict,
//            overrun out)
//
// Parameters:
//   DEBOUNCE     : cycles a synced level must differ before it is accepted
//   MIN_GAP      : idle cycles enforced between two output pulses
//   SET_PRIORITY : 0 = clear wins a simultaneous request, 1 = set wins
// ---------------------------------------------------------------------------
module sr_cmd_gen #(
    parameter int DEBOUNCE     = 4,
    parameter int MIN_GAP      = 2,
    parameter bit SET_PRIORITY = 1'b0
) (
    input  logic    clk,
    input  logic    reset,
    sr_cmd_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE) + 1;
    localparam int GW = $clog2(MIN_GAP + 1) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP);

    // GAP covers the pulse cycle plus the MIN_GAP idle cycles after it.
    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    logic [1:0]    set_sync;
    logic [1:0]    clr_sync;
    logic          set_stable;
    logic          clr_stable;
    logic [CW-1:0] set_cnt;
    logic [CW-1:0] clr_cnt;
    logic          set_pend;
    logic          clr_pend;
    state_t        state;
    state_t        state_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_next;
    logic          s_q;
    logic          r_q;
    logic          conflict_q;
    logic          overrun_q;

    logic          set_accept;
    logic          clr_accept;
    logic          set_rise;
    logic          clr_rise;
    logic          can_issue;
    logic          both_pend;
    logic          issue_s;
    logic          issue_r;
    logic          set_pend_next;
    logic          clr_pend_next;
    logic          overrun_next;

    // Two-flop synchronisers; bit 1 is the synchronised level.
    always_ff @(posedge clk) begin
        if (reset) begin
            set_sync <= 2'b00;
            clr_sync <= 2'b00;
        end else begin
            set_sync <= {set_sync[0], bus.set_in};
            clr_sync <= {clr_sync[0], bus.clr_in};
        end
    end

    // A new level is accepted on the edge where it has differed from the
    // stable level for DEBOUNCE consecutive samples; only 0->1 is a request.
    always_comb begin
        set_accept = (set_sync[1] != set_stable) && (set_cnt == CNT_LAST);
        clr_accept = (clr_sync[1] != clr_stable) && (clr_cnt == CNT_LAST);
        set_rise   = set_accept && set_sync[1];
        clr_rise   = clr_accept && clr_sync[1];
    end

    // Debounce counters and accepted levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            set_stable <= 1'b0;
            clr_stable <= 1'b0;
            set_cnt    <= '0;
            clr_cnt    <= '0;
        end else begin
            if (set_sync[1] == set_stable) begin
                set_cnt <= '0;
            end else if (set_accept) begin
                set_stable <= set_sync[1];
                set_cnt    <= '0;
            end else begin
                set_cnt <= set_cnt + 1'b1;
            end

            if (clr_sync[1] == clr_stable) begin
                clr_cnt <= '0;
            end else if (clr_accept) begin
                clr_stable <= clr_sync[1];
                clr_cnt    <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Arbitration and spacing. The last gap cycle is itself an arbitration
    // point, so a waiting request goes out exactly MIN_GAP+1 cycles after the
    // previous pulse; with MIN_GAP=0 that yields back-to-back pulses.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        issue_s    = 1'b0;
        issue_r    = 1'b0;
        can_issue  = (state == IDLE) || (gap_cnt == GAP_LAST);
        both_pend  = set_pend && clr_pend;

        if (can_issue) begin
            if (both_pend) begin
                issue_s = SET_PRIORITY;
                issue_r = !SET_PRIORITY;
            end else begin
                issue_s = set_pend;
                issue_r = clr_pend;
            end
        end

        if (issue_s || issue_r) begin
            state_next = GAP;
            gap_next   = '0;
        end else if (state == GAP) begin
            if (gap_cnt == GAP_LAST) begin
                state_next = IDLE;
                gap_next   = '0;
            end else begin
                gap_next = gap_cnt + 1'b1;
            end
        end

        // A rise on the edge that consumes the pending request re-arms it
        // cleanly; a rise onto a still-pending request coalesces and flags.
        set_pend_next = (set_pend && !issue_s) || set_rise;
        clr_pend_next = (clr_pend && !issue_r) || clr_rise;
        overrun_next  = (set_rise && set_pend && !issue_s) ||
                        (clr_rise && clr_pend && !issue_r);
    end

    // State, pending flags and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            set_pend   <= 1'b0;
            clr_pend   <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_next;
            gap_cnt    <= gap_next;
            set_pend   <= set_pend_next;
            clr_pend   <= clr_pend_next;
            s_q        <= issue_s;
            r_q        <= issue_r;
            conflict_q <= can_issue && both_pend;
            overrun_q  <= overrun_next;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.busy     = (state == GAP);
    assign bus.conflict = conflict_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_gen
// Drives three sr_cmd_gen instances from the same raw request lines:
//   main  : DEBOUNCE=4, MIN_GAP=2, clear priority
//   noGap : DEBOUNCE=4, MIN_GAP=0, clear priority
//   fast  : DEBOUNCE=1, MIN_GAP=4, set priority
// A request-level model predicts every output of every instance each cycle,
// and directed scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_sr_cmd_gen;

    localparam int NINST = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic setIn = 1'b0;
    logic clrIn = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_cmd_if ifMain();
    sr_cmd_if ifNoGap();
    sr_cmd_if ifFast();

    assign ifMain.set_in  = setIn;
    assign ifMain.clr_in  = clrIn;
    assign ifNoGap.set_in = setIn;
    assign ifNoGap.clr_in = clrIn;
    assign ifFast.set_in  = setIn;
    assign ifFast.clr_in  = clrIn;

    sr_cmd_gen #(.DEBOUNCE(4), .MIN_GAP(2), .SET_PRIORITY(1'b0)) dutMain (
        .clk(clk), .reset(reset), .bus(ifMain)
    );
    sr_cmd_gen #(.DEBOUNCE(4), .MIN_GAP(0), .SET_PRIORITY(1'b0)) dutNoGap (
        .clk(clk), .reset(reset), .bus(ifNoGap)
    );
    sr_cmd_gen #(.DEBOUNCE(1), .MIN_GAP(4), .SET_PRIORITY(1'b1)) dutFast (
        .clk(clk), .reset(reset), .bus(ifFast)
    );

    // Outputs packed as {s, r, busy, conflict, overrun}
    logic [4:0] got [NINST];
    assign got[0] = {ifMain.s,  ifMain.r,  ifMain.busy,  ifMain.conflict,  ifMain.overrun};
    assign got[1] = {ifNoGap.s, ifNoGap.r, ifNoGap.busy, ifNoGap.conflict, ifNoGap.overrun};
    assign got[2] = {ifFast.s,  ifFast.r,  ifFast.busy,  ifFast.conflict,  ifFast.overrun};

    int debParam  [NINST] = '{4, 4, 1};
    int gapParam  [NINST] = '{2, 0, 4};
    int prioParam [NINST] = '{0, 0, 1};

    // Inputs as seen by the DUTs at each rising edge
    logic capRst;
    logic capSet;
    logic capClr;
    bit   capValid;

    always @(posedge clk) begin
        capRst   <= reset;
        capSet   <= setIn;
        capClr   <= clrIn;
        capValid <= 1'b1;
    end

    // Model state: raw-sample history per channel (0 = set, 1 = clear),
    // accepted level and mismatch run length, pending requests, and the
    // earliest edge at which the next pulse may be issued.
    int  hist [2][$];
    bit  level [2][NINST];
    int  runLen [2][NINST];
    bit  pend [2][NINST];
    int  nextOk [NINST];
    int  edgeNum = 0;
    bit  modelValid = 1'b0;
    bit  expS [NINST];
    bit  expR [NINST];
    bit  expBusy [NINST];
    bit  expConf [NINST];
    bit  expOv [NINST];

    task automatic cmp(input string name, input int inst, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst=%0d t=%0t got=%b expected=%b", name, inst, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Advance the model by the edge whose inputs were captured last.
    task automatic stepModel();
        bit raw [2];
        bit synced [2];
        bit rise [2];
        bit canIssue;
        bit issue [2];
        raw[0] = capSet;
        raw[1] = capClr;
        edgeNum++;
        if (capRst) begin
            modelValid = 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch].delete();
                for (int i = 0; i < NINST; i++) begin
                    level[ch][i]  = 1'b0;
                    runLen[ch][i] = 0;
                    pend[ch][i]   = 1'b0;
                end
            end
            for (int i = 0; i < NINST; i++) begin
                nextOk[i]  = edgeNum;
                expS[i]    = 1'b0;
                expR[i]    = 1'b0;
                expBusy[i] = 1'b0;
                expConf[i] = 1'b0;
                expOv[i]   = 1'b0;
            end
        end else if (modelValid) begin
            // The synchronised level is the raw sample from two edges back.
            for (int ch = 0; ch < 2; ch++) begin
                synced[ch] = (hist[ch].size() >= 2) ? hist[ch][0] : 1'b0;
                hist[ch].push_back(raw[ch]);
                if (hist[ch].size() > 2) void'(hist[ch].pop_front());
            end
            for (int i = 0; i < NINST; i++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    rise[ch] = 1'b0;
                    if (synced[ch] != level[ch][i]) begin
                        runLen[ch][i]++;
                        if (runLen[ch][i] >= debParam[i]) begin
                            level[ch][i]  = synced[ch];
                            runLen[ch][i] = 0;
                            rise[ch]      = synced[ch];
                        end
                    end else begin
                        runLen[ch][i] = 0;
                    end
                end
                canIssue = (edgeNum >= nextOk[i]);
                issue[0] = canIssue && pend[0][i] && (!pend[1][i] || prioParam[i] == 1);
                issue[1] = canIssue && pend[1][i] && (!pend[0][i] || prioParam[i] == 0);
                expConf[i] = canIssue && pend[0][i] && pend[1][i];
                if (issue[0] || issue[1]) nextOk[i] = edgeNum + 1 + gapParam[i];
                expS[i]    = issue[0];
                expR[i]    = issue[1];
                expBusy[i] = (edgeNum < nextOk[i]);
                expOv[i]   = 1'b0;
                for (int ch = 0; ch < 2; ch++) begin
                    if (rise[ch] && pend[ch][i] && !issue[ch]) expOv[i] = 1'b1;
                    pend[ch][i] = (pend[ch][i] && !issue[ch]) || rise[ch];
                end
            end
        end
    endtask

    // Every falling edge: update the model for the preceding rising edge and
    // hold all three instances against it.
    initial begin
        forever begin
            @(negedge clk);
            if (capValid) begin
                stepModel();
                if (modelValid) begin
                    for (int i = 0; i < NINST; i++) begin
                        cmp("s",        i, got[i][4], expS[i]);
                        cmp("r",        i, got[i][3], expR[i]);
                        cmp("busy",     i, got[i][2], expBusy[i]);
                        cmp("conflict", i, got[i][1], expConf[i]);
                        cmp("overrun",  i, got[i][0], expOv[i]);
                        cmp("s_and_r",  i, got[i][4] & got[i][3], 1'b0);
                    end
                end
            end
        end
    end

    // Drive the raw lines at a falling edge, then let n cycles pass.
    task automatic applyStimulus(input logic sv, input logic cv, input int n);
        setIn = sv;
        clrIn = cv;
        repeat (n) @(negedge clk);
    endtask

    task automatic countPulses(input int n, output int sMain, output int rMain);
        sMain = 0;
        rMain = 0;
        repeat (n) begin
            @(negedge clk);
            sMain += int'(ifMain.s);
            rMain += int'(ifMain.r);
        end
    endtask

    bit ovPat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int sc;
        int rc;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_s",        ifMain.s,        1'b0);
        checkOutput("reset_r",        ifMain.r,        1'b0);
        checkOutput("reset_busy",     ifMain.busy,     1'b0);
        checkOutput("reset_conflict", ifMain.conflict, 1'b0);
        checkOutput("reset_overrun",  ifMain.overrun,  1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 5);

        // Basic set: pulse seven cycles after the first sampling edge
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("set_early_s", ifMain.s, 1'b0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("set_pulse_s",    ifMain.s,    1'b1);
        checkOutput("set_pulse_r",    ifMain.r,    1'b0);
        checkOutput("set_pulse_busy", ifMain.busy, 1'b1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("set_after_s", ifMain.s,    1'b0);
        checkOutput("set_gap1",    ifMain.busy, 1'b1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("set_gap2", ifMain.busy, 1'b1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("set_idle_busy", ifMain.busy, 1'b0);
        countPulses(10, sc, rc);
        checkCount("set_held_no_repeat", sc, 0);
        applyStimulus(1'b0, 1'b0, 12);

        // Glitch shorter than the debounce window, then one just long enough
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 0);
        countPulses(12, sc, rc);
        checkCount("glitch3_r", rc, 0);
        applyStimulus(1'b0, 1'b1, 4);
        applyStimulus(1'b0, 1'b0, 0);
        countPulses(14, sc, rc);
        checkCount("glitch4_r", rc, 1);
        applyStimulus(1'b0, 1'b0, 6);

        // Simultaneous requests: clear first, set after the gap
        applyStimulus(1'b1, 1'b1, 7);
        checkOutput("sim_r",          ifMain.r,         1'b1);
        checkOutput("sim_conflict",   ifMain.conflict,  1'b1);
        checkOutput("sim_s_held",     ifMain.s,         1'b0);
        checkOutput("nogap_r",        ifNoGap.r,        1'b1);
        checkOutput("nogap_conflict", ifNoGap.conflict, 1'b1);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("sim_gap1_s", ifMain.s,  1'b0);
        checkOutput("nogap_s",    ifNoGap.s, 1'b1);
        checkOutput("nogap_r_off", ifNoGap.r, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("sim_gap2_s", ifMain.s, 1'b0);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("sim_s",          ifMain.s,        1'b1);
        checkOutput("sim_s_conflict", ifMain.conflict, 1'b0);
        applyStimulus(1'b0, 1'b0, 12);

        // Overrun on the fast instance: second set edge during its gap
        setIn = 1'b1;
        for (int m = 1; m <= 11; m++) begin
            @(negedge clk);
            checkOutput($sformatf("ovr_s_%0d", m),  ifFast.s,       (m == 4 || m == 9));
            checkOutput($sformatf("ovr_flag_%0d", m), ifFast.overrun, (m == 8));
            setIn = (m < 6) ? ovPat[m] : 1'b1;
        end
        applyStimulus(1'b0, 1'b0, 12);

        // Reset during the gap with a clear pending
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 6);
        checkOutput("rst_pre_s", ifMain.s, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rst_s",        ifMain.s,        1'b0);
        checkOutput("rst_r",        ifMain.r,        1'b0);
        checkOutput("rst_busy",     ifMain.busy,     1'b0);
        checkOutput("rst_conflict", ifMain.conflict, 1'b0);
        checkOutput("rst_overrun",  ifMain.overrun,  1'b0);
        reset = 1'b0;
        countPulses(20, sc, rc);
        checkCount("rst_lost_r", rc, 0);
        checkCount("rst_lost_s", sc, 0);

        // Request held high across reset is seen again afterwards
        applyStimulus(1'b1, 1'b0, 12);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1);
        reset = 1'b0;
        countPulses(15, sc, rc);
        checkCount("held_through_reset_s", sc, 1);
        applyStimulus(1'b0, 1'b0, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
